// File: rtl/fp_argmin_search_pkg.sv
// rtl/fp_argmin_search_pkg.sv - shared state encoding and fixed-point format helpers
package fp_argmin_search_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int FP_N_DEFAULT = 32;
    localparam int FP_Q_DEFAULT = 16;

    function automatic int sign_bit(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/fp_argmin_search_fplessthan.sv
// rtl/fp_argmin_search_fplessthan.sv - combinational sign-magnitude a < b compare
module fplessthan
    import fp_argmin_search_pkg::*;
#(
    parameter int Q = FP_Q_DEFAULT,
    parameter int N = FP_N_DEFAULT
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         c
);

    localparam int SB = sign_bit(N);

    logic [SB-1:0] ma;
    logic [SB-1:0] mb;
    logic          neg_a;
    logic          neg_b;
    logic          mag_lt;
    logic          mag_gt;

    assign ma = a[SB-1:0];
    assign mb = b[SB-1:0];

    // A zero magnitude counts as non-negative so +0 and -0 compare equal.
    assign neg_a = a[SB] && (ma != '0);
    assign neg_b = b[SB] && (mb != '0);

    // Integer part first, then fraction; equivalent to a plain magnitude compare.
    assign mag_lt = (ma[SB-1:Q] < mb[SB-1:Q]) ||
                    ((ma[SB-1:Q] == mb[SB-1:Q]) && (ma[Q-1:0] < mb[Q-1:0]));
    assign mag_gt = (mb[SB-1:Q] < ma[SB-1:Q]) ||
                    ((mb[SB-1:Q] == ma[SB-1:Q]) && (mb[Q-1:0] < ma[Q-1:0]));

    always_comb begin
        if (neg_a != neg_b) begin
            c = neg_a;
        end else if (neg_a) begin
            c = mag_gt;
        end else begin
            c = mag_lt;
        end
    end

endmodule

// File: rtl/fp_argmin_search.sv
// rtl/fp_argmin_search.sv - streaming minimum value and first-index finder
module fp_argmin_search
    import fp_argmin_search_pkg::*;
#(
    parameter int Q    = FP_Q_DEFAULT,
    parameter int N    = FP_N_DEFAULT,
    parameter int IDXW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            in_valid,
    input  logic [N-1:0]    in_data,
    input  logic            in_last,
    output logic            in_ready,
    output logic            busy,
    output logic            out_valid,
    output logic [N-1:0]    out_min,
    output logic [IDXW-1:0] out_idx,
    output logic            out_ovf,
    input  logic            out_ready
);

    state_t          state;
    state_t          state_nxt;
    logic [IDXW-1:0] count;
    logic            cnt_full;
    logic            have_min;
    logic            ovf;
    logic [N-1:0]    min_q;
    logic [IDXW-1:0] idx_q;
    logic            lt;
    logic            accept;

    fplessthan #(.Q(Q), .N(N)) u_cmp (
        .a (in_data),
        .b (min_q),
        .c (lt)
    );

    assign accept = (state == ST_SEARCH) && in_valid;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_SEARCH;
            end
            ST_SEARCH: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && in_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // cnt_full marks that the beat at the all-ones index was taken, so the next beat overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            cnt_full <= 1'b0;
            have_min <= 1'b0;
            ovf      <= 1'b0;
            min_q    <= '0;
            idx_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                count    <= '0;
                cnt_full <= 1'b0;
                have_min <= 1'b0;
                ovf      <= 1'b0;
            end
            if (accept) begin
                if (!have_min || lt) begin
                    min_q    <= in_data;
                    idx_q    <= count;
                    have_min <= 1'b1;
                end
                if (count == {IDXW{1'b1}}) begin
                    if (cnt_full) ovf <= 1'b1;
                    cnt_full <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    assign out_min = min_q;
    assign out_idx = idx_q;
    assign out_ovf = ovf;

endmodule

// File: doc/fp_argmin_search.md
Name: fp_argmin_search

Overview:
Streaming minimum finder for N-bit sign-magnitude fixed-point values (MSB sign, bits N-2:0 magnitude, Q fractional bits). It accepts a burst of samples over a valid/ready handshake and reports the smallest value and the index of its first occurrence. It serves as the search engine behind codebook and LSP nearest-entry selection in the encoder, and uses the less-than direction of the team's fixed-point compare.

Parameters:
Q, 16, fractional bits of sample format (informational; ordering is independent of Q)
N, 32, total sample width including sign bit
IDXW, 8, width of sample index / result index

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a new search when idle
in_valid  in  1  sample present on in_data
in_data  in  N  sign-magnitude sample
in_last  in  1  marks final sample of burst, qualified by in_valid
in_ready  out  1  block accepts a sample this cycle
busy  out  1  high in SEARCH and DONE
out_valid  out  1  result available; held until out_ready
out_min  out  N  minimum sample value
out_idx  out  IDXW  zero-based index of first occurrence of minimum
out_ovf  out  1  burst exceeded 2^IDXW samples
out_ready  in  1  consumer takes the result

Behaviour:
- Ordering: sign-magnitude; +0 and -0 compare equal. Among negatives, larger magnitude is smaller. Strict less-than only, so ties keep the earliest index.
- Reset (async assert, sync release): state IDLE; in_ready, busy, out_valid, out_ovf = 0; out_min, out_idx = 0; internal count and have_min cleared.
- States: IDLE, SEARCH, DONE; encoding in shared package.
- IDLE:
  - in_ready = 0.
  - start = 1 moves to SEARCH next cycle, clears count, have_min and ovf.
  - in_valid is ignored in IDLE, including when it arrives in the same cycle as start.
- SEARCH:
  - in_ready = 1, busy = 1.
  - A beat is accepted when in_valid and in_ready are both high.
  - On an accepted beat, if have_min = 0 or in_data < min: min <= in_data, idx <= count, have_min <= 1.
  - count increments per accepted beat.
  - start is ignored in SEARCH.
- Accepted beat with in_last: moves to DONE. out_valid rises the next cycle, with out_min/out_idx including that final beat (1-cycle latency from last beat).
- DONE:
  - in_ready = 0.
  - out_valid, out_min, out_idx and out_ovf are held stable while out_ready = 0.
  - out_ready = 1 moves to IDLE next cycle and drops out_valid.
  - start is ignored in DONE, including in the same cycle as out_ready.
  - out_min and out_idx retain their values in IDLE until the next winning sample.
- Index overflow:
  - When count = 2^IDXW-1 and a further beat is accepted, out_ovf becomes sticky high and count saturates at all-ones.
  - Later winners record idx = all-ones.
  - The search continues normally.
- Reset mid-operation aborts immediately to the reset values; no partial result is emitted.
- Comparator is purely combinational; no extra pipeline stage. Single sample per cycle throughput.

Decomposition:
- Shared package/include: state encoding constants (IDLE, SEARCH, DONE), sign-bit index helper, default N/Q values used across fixed-point blocks.
- One sub-module, fplessthan (parameters Q, N; inputs a, b; output c = a<b), combinational. It is instantiated once to compare in_data against the running min.
- FSM, counter and registers live in fp_argmin_search.

Test Plan:
1. Reset, start, stream 0x00018000 (+1.5), 0x80004000 (-0.25), 0x0000C000 (+0.75, last) -> out_valid 1 cycle after last; out_min=0x80004000, out_idx=1, out_ovf=0.
2. Stream 0x80010000 (-1.0), 0x80020000 (-2.0), 0x00000000 (last) -> out_min=0x80020000, out_idx=1. Stream 0x00010000, 0x00010000, 0x00020000 (last) -> out_idx=0 (tie keeps first).
3. Stream 0x00000000 (+0), 0x80000000 (-0, last) -> out_min=0x00000000, out_idx=0. Zeros compare equal.
4. Single sample 0x00030000 with in_last; hold out_ready=0 for 5 cycles and pulse start -> outputs stable, busy=1, start ignored. Then out_ready=1 -> IDLE next cycle, out_valid=0.
5. IDXW=2: stream 6 samples, minimum 0x80050000 at index 5 -> out_ovf=1, out_idx=3 (saturated), out_min=0x80050000.
6. Deassert rst_n after 2 beats of a burst -> outputs zero immediately. A fresh search then returns correct results with no carry-over of the old min.
